nvram_upload_reader: RTL and testbench

// - Read side of the HPS ioctl file channel: serves ioctl upload (HPS reads core) for hiscore/NVRAM save.
// - Complements the existing download path (ioctl_wr into ROM/DIP); that path stays unchanged.
// - Sits in emu beside hps_io. Steals read cycles on the game work-RAM port only while ram_gnt is high.
// - Holds the HPS off with ioctl_wait until each byte is valid.

---
 rtl/nvram_upload_reader_pkg.sv | 20 ++
 rtl/nvram_upload_reader_if.sv | 27 ++
 rtl/nvram_upload_reader.sv | 111 +++++++++++
 tb/tb_nvram_upload_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_upload_reader_pkg.sv
// Shared types and constants for the NVRAM/hiscore upload reader.
package nvram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    READ,
    LAT,
    DONE
  } state_t;

  localparam logic [7:0] UPLOAD_INDEX_HISCORE = 8'd4;
  localparam int         IOCTL_AW             = 25;

  // Session checksum wraps modulo 2^16.
  function automatic logic [15:0] csum_add(input logic [15:0] sum, input logic [7:0] b);
    return sum + {8'h00, b};
  endfunction

endpackage

// File: rtl/nvram_upload_reader_if.sv
// ioctl upload channel plus the stolen work-RAM read port, bundled for the reader.
interface nvram_upload_reader_if #(
  parameter int AW = 11
);
  logic          ioctl_upload;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_index;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          ram_gnt;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_q;

  // Environment side: hps_io and the RAM arbiter.
  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, ram_gnt, ram_q,
    input  ioctl_din, ioctl_wait, ram_rd, ram_addr
  );

  // Reader side.
  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, ram_gnt, ram_q,
    output ioctl_din, ioctl_wait, ram_rd, ram_addr
  );
endinterface

// File: rtl/nvram_upload_reader.sv
// Serves HPS ioctl uploads of game work-RAM, stealing RAM read cycles only while
// ram_gnt is high and stalling the HPS with ioctl_wait until each byte is ready.
module nvram_upload_reader
  import nvram_pkg::*;
#(
  parameter logic [7:0] INDEX   = UPLOAD_INDEX_HISCORE,
  parameter int         AW      = 11,
  parameter int         SIZE    = 2048,
  parameter int         RAM_LAT = 2,
  parameter logic [7:0] FILL    = 8'hFF
) (
  input  logic                  clk_sys,
  input  logic                  RESET,
  nvram_upload_reader_if.slave  io,
  output logic                  pause_req,
  output logic [15:0]           csum
);

  state_t        state;
  logic [AW-1:0] addr_p0;
  logic [2:0]    lat_cnt;
  logic [7:0]    din_r;
  logic          wait_r;
  logic          ram_rd_r;
  logic [AW-1:0] ram_addr_r;
  logic          sel;
  logic          out_of_range;

  assign sel          = io.ioctl_upload & (io.ioctl_index == INDEX);
  assign out_of_range = io.ioctl_addr >= IOCTL_AW'(SIZE);

  assign io.ioctl_din  = din_r;
  assign io.ioctl_wait = wait_r;
  assign io.ram_rd     = ram_rd_r;
  assign io.ram_addr   = ram_addr_r;

  // pause_req doubles as the delayed sel, so sel & ~pause_req marks a session start.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      addr_p0    <= '0;
      lat_cnt    <= '0;
      din_r      <= '0;
      wait_r     <= 1'b0;
      ram_rd_r   <= 1'b0;
      ram_addr_r <= '0;
      pause_req  <= 1'b0;
      csum       <= '0;
    end else begin
      pause_req <= sel;
      ram_rd_r  <= 1'b0;

      if (!sel && state != IDLE) begin
        // Session dropped mid-transfer: release the HPS, discard any RAM data.
        state  <= IDLE;
        wait_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (io.ioctl_rd && sel) begin
              addr_p0 <= io.ioctl_addr[AW-1:0];
              wait_r  <= 1'b1;
              if (out_of_range) begin
                din_r <= FILL;
                state <= DONE;
              end else begin
                state <= ARB;
              end
            end
          end

          // Grant is only looked at here; once ram_rd is out the read completes.
          ARB: begin
            if (io.ram_gnt) begin
              ram_rd_r   <= 1'b1;
              ram_addr_r <= addr_p0;
              state      <= READ;
            end
          end

          READ: begin
            lat_cnt <= 3'(RAM_LAT - 1);
            state   <= LAT;
          end

          LAT: begin
            if (lat_cnt == 3'd0) begin
              din_r <= io.ram_q;
              state <= DONE;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end

          DONE: begin
            wait_r <= 1'b0;
            csum   <= csum_add(csum, din_r);
            state  <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end

      if (sel && !pause_req) begin
        csum <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Randomized self-checking bench for nvram_upload_reader against a byte-level reference model.
module tb_nvram_upload_reader;
  import nvram_pkg::*;

  localparam int         AW      = 11;
  localparam int         SIZE    = 2048;
  localparam int         RAM_LAT = 2;
  localparam logic [7:0] FILL    = 8'hFF;
  localparam logic [7:0] INDEX   = UPLOAD_INDEX_HISCORE;

  logic        clk_sys = 1'b0;
  logic        RESET   = 1'b1;
  logic        pause_req;
  logic [15:0] csum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [SIZE];
  logic [7:0]  pipe [RAM_LAT];
  int          rd_count = 0;
  logic [AW-1:0] last_ram_addr = '0;
  logic [15:0] exp_csum = 16'h0;

  nvram_upload_reader_if #(.AW(AW)) bus ();

  nvram_upload_reader #(
    .INDEX  (INDEX),
    .AW     (AW),
    .SIZE   (SIZE),
    .RAM_LAT(RAM_LAT),
    .FILL   (FILL)
  ) dut (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .io       (bus.slave),
    .pause_req(pause_req),
    .csum     (csum)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: data appears RAM_LAT cycles after the ram_rd cycle, garbage otherwise.
  always @(posedge clk_sys) begin
    pipe[0] <= bus.ram_rd ? mem[bus.ram_addr] : 8'($urandom);
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ram_q = pipe[RAM_LAT-1];

  always @(posedge clk_sys) begin
    if (bus.ram_rd) begin
      rd_count      <= rd_count + 1;
      last_ram_addr <= bus.ram_addr;
    end
  end

  function automatic logic [7:0] ref_byte(input logic [24:0] a);
    return (a < 25'(SIZE)) ? mem[a[AW-1:0]] : FILL;
  endfunction

  task automatic do_read(input logic [24:0] a, output int lat, output logic [7:0] d);
    @(negedge clk_sys);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    lat = 1;
    while (bus.ioctl_wait === 1'b1 && lat < 200) begin
      @(negedge clk_sys);
      lat++;
    end
    if (lat >= 200) lat = -1;
    d = bus.ioctl_din;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    n_cmp++; if (bus.ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL reset_wait got %0b want 0", bus.ioctl_wait); end
    n_cmp++; if (bus.ioctl_din !== 8'h00) begin n_bad++; $display("FAIL reset_din got %h want 00", bus.ioctl_din); end
    n_cmp++; if (pause_req !== 1'b0) begin n_bad++; $display("FAIL reset_pause got %0b want 0", pause_req); end
    n_cmp++; if (csum !== 16'h0) begin n_bad++; $display("FAIL reset_csum got %h want 0000", csum); end
    n_cmp++; if (bus.ram_rd !== 1'b0) begin n_bad++; $display("FAIL reset_ram_rd got %0b want 0", bus.ram_rd); end
    n_cmp++; if (bus.ram_addr !== '0) begin n_bad++; $display("FAIL reset_ram_addr got %h want 0", bus.ram_addr); end
    RESET = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_index  = INDEX;
    bus.ioctl_upload = 1'b1;
    n_cmp++; if (pause_req !== 1'b0) begin n_bad++; $display("FAIL pause_before_sel got %0b want 0", pause_req); end
    @(negedge clk_sys);
    exp_csum = 16'h0;
    n_cmp++; if (pause_req !== 1'b1) begin n_bad++; $display("FAIL pause_rise got %0b want 1", pause_req); end
  endtask

  task automatic test_single();
    int lat; logic [7:0] d; int c0;
    mem[16'h010] = 8'hA5;
    bus.ram_gnt = 1'b1;
    c0 = rd_count;
    do_read(25'h010, lat, d);
    exp_csum = exp_csum + 16'hA5;
    n_cmp++; if (d !== 8'hA5) begin n_bad++; $display("FAIL t1_din got %h want a5", d); end
    n_cmp++; if (lat != 4 + RAM_LAT) begin n_bad++; $display("FAIL t1_latency got %0d want %0d", lat, 4 + RAM_LAT); end
    n_cmp++; if (rd_count - c0 != 1) begin n_bad++; $display("FAIL t1_ram_rd_pulses got %0d want 1", rd_count - c0); end
    n_cmp++; if (last_ram_addr !== 11'h010) begin n_bad++; $display("FAIL t1_ram_addr got %h want 010", last_ram_addr); end
    n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL t1_csum got %h want %h", csum, exp_csum); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [7:0] d; int c0;
    c0 = rd_count;
    do_read(25'h900, lat, d);
    exp_csum = exp_csum + 16'(FILL);
    n_cmp++; if (d !== FILL) begin n_bad++; $display("FAIL t2_din got %h want %h", d, FILL); end
    n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL t2_latency got %0d want 2", lat); end
    n_cmp++; if (rd_count != c0) begin n_bad++; $display("FAIL t2_no_ram_rd got %0d want 0", rd_count - c0); end
    n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL t2_csum got %h want %h", csum, exp_csum); end
  endtask

  task automatic test_grant_stall();
    int c0; int lat; logic ok;
    logic [24:0] a;
    a = 25'($urandom_range(0, SIZE - 1));
    c0 = rd_count;
    ok = 1'b1;
    bus.ram_gnt = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      // A strobe while busy must be ignored.
      if (i == 5) begin bus.ioctl_addr = a ^ 25'h5; bus.ioctl_rd = 1'b1; end
      if (i == 6) bus.ioctl_rd = 1'b0;
      if (bus.ioctl_wait !== 1'b1 || rd_count != c0) ok = 1'b0;
      @(negedge clk_sys);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t3_stall_hold got wait=%0b rd=%0d want wait=1 rd=0", bus.ioctl_wait, rd_count - c0); end
    bus.ram_gnt = 1'b1;
    lat = 0;
    while (bus.ioctl_wait === 1'b1 && lat < 200) begin
      @(negedge clk_sys);
      lat++;
    end
    exp_csum = exp_csum + 16'(ref_byte(a));
    // The IDLE stage is already behind us, so grant-to-release is one cycle short of the full latency.
    n_cmp++; if (lat != 3 + RAM_LAT) begin n_bad++; $display("FAIL t3_grant_latency got %0d want %0d", lat, 3 + RAM_LAT); end
    n_cmp++; if (bus.ioctl_din !== ref_byte(a)) begin n_bad++; $display("FAIL t3_din got %h want %h", bus.ioctl_din, ref_byte(a)); end
    n_cmp++; if (rd_count - c0 != 1) begin n_bad++; $display("FAIL t3_ram_rd_pulses got %0d want 1", rd_count - c0); end
    n_cmp++; if (last_ram_addr !== a[AW-1:0]) begin n_bad++; $display("FAIL t3_ram_addr got %h want %h", last_ram_addr, a[AW-1:0]); end
    n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL t3_csum got %h want %h", csum, exp_csum); end
  endtask

  task automatic new_session();
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (pause_req !== 1'b0) begin n_bad++; $display("FAIL session_pause_fall got %0b want 0", pause_req); end
    bus.ioctl_upload = 1'b1;
    @(negedge clk_sys);
    exp_csum = 16'h0;
    n_cmp++; if (pause_req !== 1'b1) begin n_bad++; $display("FAIL session_pause_rise got %0b want 1", pause_req); end
    n_cmp++; if (csum !== 16'h0) begin n_bad++; $display("FAIL session_csum_clear got %h want 0000", csum); end
  endtask

  task automatic test_csum_session();
    int lat; logic [7:0] d;
    logic [7:0] vals [4];
    vals = '{8'h01, 8'h02, 8'h03, 8'hFE};
    new_session();
    for (int i = 0; i < 4; i++) mem[i] = vals[i];
    for (int i = 0; i < 4; i++) begin
      do_read(25'(i), lat, d);
      exp_csum = exp_csum + 16'(vals[i]);
      n_cmp++; if (d !== vals[i]) begin n_bad++; $display("FAIL t4_din[%0d] got %h want %h", i, d, vals[i]); end
    end
    n_cmp++; if (csum !== 16'h0104 || exp_csum !== 16'h0104) begin n_bad++; $display("FAIL t4_csum got %h want 0104", csum); end
    new_session();
  endtask

  task automatic test_random();
    int lat; logic [7:0] d; int exp_lat;
    logic [24:0] a;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) a = 25'($urandom_range(0, SIZE - 1));
      else                           a = 25'($urandom_range(SIZE, 32'h1FF_FFFF));
      exp_lat = (a < 25'(SIZE)) ? 4 + RAM_LAT : 2;
      do_read(a, lat, d);
      exp_csum = exp_csum + 16'(ref_byte(a));
      n_cmp++; if (d !== ref_byte(a)) begin n_bad++; $display("FAIL rand_din addr=%h got %h want %h", a, d, ref_byte(a)); end
      n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL rand_latency addr=%h got %0d want %0d", a, lat, exp_lat); end
      n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL rand_csum addr=%h got %h want %h", a, csum, exp_csum); end
    end
  endtask

  task automatic test_abort_in_lat();
    int lat; logic [7:0] d;
    logic [24:0] a;
    a = 25'($urandom_range(0, SIZE - 1));
    bus.ram_gnt = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
    bus.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (bus.ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL t5_wait got %0b want 0", bus.ioctl_wait); end
    n_cmp++; if (pause_req !== 1'b0) begin n_bad++; $display("FAIL t5_pause got %0b want 0", pause_req); end
    n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL t5_csum got %h want %h", csum, exp_csum); end
    repeat (4) @(negedge clk_sys);
    n_cmp++; if (csum !== exp_csum || bus.ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL t5_settled csum=%h wait=%0b want csum=%h wait=0", csum, bus.ioctl_wait, exp_csum); end
    bus.ioctl_upload = 1'b1;
    @(negedge clk_sys);
    exp_csum = 16'h0;
    do_read(a, lat, d);
    exp_csum = exp_csum + 16'(ref_byte(a));
    n_cmp++; if (lat != 4 + RAM_LAT) begin n_bad++; $display("FAIL t5_resume_latency got %0d want %0d", lat, 4 + RAM_LAT); end
    n_cmp++; if (d !== ref_byte(a)) begin n_bad++; $display("FAIL t5_resume_din got %h want %h", d, ref_byte(a)); end
    n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL t5_resume_csum got %h want %h", csum, exp_csum); end
  endtask

  task automatic test_other_index_and_reset();
    int c0; logic ok; int lat; logic [7:0] d;
    @(negedge clk_sys);
    bus.ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
    bus.ioctl_index  = 8'd0;
    bus.ioctl_upload = 1'b1;
    c0 = rd_count;
    ok = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h010;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.ioctl_wait !== 1'b0 || pause_req !== 1'b0 || rd_count != c0) ok = 1'b0;
      @(negedge clk_sys);
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL t6_ignore got wait=%0b pause=%0b rd=%0d want 0/0/0", bus.ioctl_wait, pause_req, rd_count - c0); end

    bus.ioctl_index = INDEX;
    @(negedge clk_sys);
    do_read(25'h1234, lat, d);
    bus.ram_gnt = 1'b0;
    @(negedge clk_sys);
    bus.ioctl_addr = 25'h010;
    bus.ioctl_rd   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (bus.ioctl_wait !== 1'b1 || bus.ioctl_din !== FILL) begin n_bad++; $display("FAIL t6_pre_reset wait=%0b din=%h want 1/%h", bus.ioctl_wait, bus.ioctl_din, FILL); end
    #1 RESET = 1'b1;
    #1;
    n_cmp++; if (bus.ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL t6_async_wait got %0b want 0", bus.ioctl_wait); end
    n_cmp++; if (bus.ioctl_din !== 8'h00) begin n_bad++; $display("FAIL t6_async_din got %h want 00", bus.ioctl_din); end
    n_cmp++; if (pause_req !== 1'b0) begin n_bad++; $display("FAIL t6_async_pause got %0b want 0", pause_req); end
    n_cmp++; if (csum !== 16'h0) begin n_bad++; $display("FAIL t6_async_csum got %h want 0000", csum); end
    n_cmp++; if (bus.ram_rd !== 1'b0 || bus.ram_addr !== '0) begin n_bad++; $display("FAIL t6_async_ram got rd=%0b addr=%h want 0/0", bus.ram_rd, bus.ram_addr); end
    @(negedge clk_sys);
    RESET = 1'b0;
    bus.ram_gnt = 1'b1;
    @(negedge clk_sys);
    exp_csum = 16'h0;
    mem[16'h010] = 8'h3C;
    do_read(25'h010, lat, d);
    exp_csum = exp_csum + 16'h3C;
    n_cmp++; if (d !== 8'h3C || lat != 4 + RAM_LAT) begin n_bad++; $display("FAIL t6_after_reset got din=%h lat=%0d want 3c/%0d", d, lat, 4 + RAM_LAT); end
    n_cmp++; if (csum !== exp_csum) begin n_bad++; $display("FAIL t6_after_reset_csum got %h want %h", csum, exp_csum); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.ioctl_upload = 1'b0;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.ioctl_index  = 8'd0;
    bus.ram_gnt      = 1'b1;
    for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_out_of_range();
    test_grant_stall();
    test_csum_session();
    test_random();
    test_abort_in_lat();
    test_other_index_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
